// File: rtl/conway_pkg.sv
// Shared constants for the Game of Life core: memory geometry defaults and the
// bring-up seed pattern loaded into cell-state memory by the debug strobe.
package conway_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 2;

  localparam logic [15:0] SEED_0 = 16'h0700;
  localparam logic [15:0] SEED_1 = 16'h3300;
  localparam logic [15:0] SEED_2 = 16'h33CC;
  localparam logic [15:0] SEED_3 = 16'h6186;

  function automatic logic [15:0] seed_word(input logic [1:0] addr);
    case (addr)
      2'd0:    return SEED_0;
      2'd1:    return SEED_1;
      2'd2:    return SEED_2;
      default: return SEED_3;
    endcase
  endfunction

endpackage

// File: rtl/block_mem_if.sv
// Bus bundle for block_mem: VGA read port, selector read/write port and the
// debug seed strobe. The master drives addresses/strobes, the slave drives read data.
interface block_mem_if import conway_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              debug;
  logic [ADDR_W-1:0] array_in_vga;
  logic [DATA_W-1:0] alive_out_vga;
  logic              write_enb;
  logic [ADDR_W-1:0] array_selector;
  logic [DATA_W-1:0] alive_in_selector;
  logic [DATA_W-1:0] alive_out_selector;

  modport master (
    output debug, array_in_vga, write_enb, array_selector, alive_in_selector,
    input  alive_out_vga, alive_out_selector
  );

  modport slave (
    input  debug, array_in_vga, write_enb, array_selector, alive_in_selector,
    output alive_out_vga, alive_out_selector
  );

endinterface

// File: rtl/block_mem.sv
// Dual-port cell-state memory: read-only VGA port plus read/write selector port.
// Define BLOCK_MEM_WRITE_FORWARD_EN for write-first selector reads (default read-first).
module block_mem import conway_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  block_mem_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]             r_mem [DEPTH];
  logic [DEPTH-1:0][DATA_W-1:0]  w_mem_next;
  logic [DATA_W-1:0]             r_out_vga;
  logic [DATA_W-1:0]             r_out_sel;
  logic [DATA_W-1:0]             w_rd_sel;

  // Per-word next value: debug reload beats a selector write.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      assign w_mem_next[gi] =
        bus.debug ? DATA_W'(seed_word(2'(gi))) :
        (bus.write_enb && (bus.array_selector == ADDR_W'(gi))) ? bus.alive_in_selector :
        r_mem[gi];
    end
  endgenerate

`ifdef BLOCK_MEM_WRITE_FORWARD_EN
  // Read and write share one address, so any write on this port is a same-address hit.
  assign w_rd_sel = bus.write_enb ? bus.alive_in_selector : r_mem[bus.array_selector];
`else
  assign w_rd_sel = r_mem[bus.array_selector];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_out_vga <= '0;
      r_out_sel <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_next[i];
      end
      // During a debug load the read registers see the seed, not stale contents.
      if (bus.debug) begin
        r_out_vga <= DATA_W'(seed_word(2'(bus.array_in_vga)));
        r_out_sel <= DATA_W'(seed_word(2'(bus.array_selector)));
      end else begin
        r_out_vga <= r_mem[bus.array_in_vga];
        r_out_sel <= w_rd_sel;
      end
    end
  end

  assign bus.alive_out_vga      = r_out_vga;
  assign bus.alive_out_selector = r_out_sel;

endmodule

// File: tb/tb_block_mem.sv
// Directed self-checking bench for block_mem; expected values are hand-computed
// from the seed table and the write/reset/debug priority rules.
`timescale 1ns/1ps
module tb_block_mem;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [15:0] seed_tbl [4];

  block_mem_if bus ();

  block_mem dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [1:0] sel, input logic [1:0] vga);
    bus.array_selector = sel;
    bus.array_in_vga   = vga;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    seed_tbl[0] = 16'h0700;
    seed_tbl[1] = 16'h3300;
    seed_tbl[2] = 16'h33CC;
    seed_tbl[3] = 16'h6186;

    reset                 = 1'b1;
    bus.debug             = 1'b0;
    bus.write_enb         = 1'b0;
    bus.alive_in_selector = 16'h0000;
    set_addr(2'd0, 2'd0);
    step();
    check_val("reset_sel", bus.alive_out_selector, 16'h0000);
    check_val("reset_vga", bus.alive_out_vga, 16'h0000);
    reset = 1'b0;

    // Fill memory, then reset while a write is still pending.
    bus.write_enb = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.array_selector    = 2'(a);
      bus.alive_in_selector = 16'hA000 + 16'(a * 16'h0111);
      step();
    end
    bus.array_selector    = 2'd1;
    bus.alive_in_selector = 16'h5555;
    reset = 1'b1;
    step();
    check_val("rst_mid_sel", bus.alive_out_selector, 16'h0000);
    check_val("rst_mid_vga", bus.alive_out_vga, 16'h0000);
    reset         = 1'b0;
    bus.write_enb = 1'b0;
    for (int a = 0; a < 4; a++) begin
      set_addr(2'(a), 2'(a));
      step();
      check_val($sformatf("rst_rd_sel%0d", a), bus.alive_out_selector, 16'h0000);
      check_val($sformatf("rst_rd_vga%0d", a), bus.alive_out_vga, 16'h0000);
    end

    // Debug load: outputs show the seed on the same edge.
    bus.debug = 1'b1;
    set_addr(2'd0, 2'd0);
    step();
    check_val("dbg_sel0", bus.alive_out_selector, 16'h0700);
    check_val("dbg_vga0", bus.alive_out_vga, 16'h0700);
    bus.debug = 1'b0;
    for (int k = 1; k < 4; k++) begin
      set_addr(2'(k), 2'((k + 2) % 4));
      step();
      check_val($sformatf("seed_sel%0d", k), bus.alive_out_selector, seed_tbl[k]);
      check_val($sformatf("seed_vga%0d", (k + 2) % 4), bus.alive_out_vga, seed_tbl[(k + 2) % 4]);
    end

    // Write BEEF to addr 2; VGA on the same address is read-first.
    bus.write_enb         = 1'b1;
    bus.alive_in_selector = 16'hBEEF;
    set_addr(2'd2, 2'd2);
    step();
`ifdef BLOCK_MEM_WRITE_FORWARD_EN
    check_val("wr_rdw_sel", bus.alive_out_selector, 16'hBEEF);
`else
    check_val("wr_rdw_sel", bus.alive_out_selector, 16'h33CC);
`endif
    check_val("wr_rdw_vga", bus.alive_out_vga, 16'h33CC);
    bus.write_enb = 1'b0;
    step();
    check_val("wr_rd_sel2", bus.alive_out_selector, 16'hBEEF);
    check_val("wr_rd_vga2", bus.alive_out_vga, 16'hBEEF);
    set_addr(2'd3, 2'd3);
    step();
    check_val("wr_rd_sel3", bus.alive_out_selector, 16'h6186);
    check_val("wr_rd_vga3", bus.alive_out_vga, 16'h6186);

    // Debug beats a same-edge write.
    bus.debug             = 1'b1;
    bus.write_enb         = 1'b1;
    bus.alive_in_selector = 16'hFFFF;
    set_addr(2'd0, 2'd0);
    step();
    check_val("prio_dbg_sel", bus.alive_out_selector, 16'h0700);
    check_val("prio_dbg_vga", bus.alive_out_vga, 16'h0700);
    bus.debug     = 1'b0;
    bus.write_enb = 1'b0;
    step();
    check_val("prio_mem_sel", bus.alive_out_selector, 16'h0700);
    check_val("prio_mem_vga", bus.alive_out_vga, 16'h0700);

    // Reset beats debug.
    reset     = 1'b1;
    bus.debug = 1'b1;
    set_addr(2'd1, 2'd1);
    step();
    check_val("prio_rst_sel", bus.alive_out_selector, 16'h0000);
    check_val("prio_rst_vga", bus.alive_out_vga, 16'h0000);
    reset     = 1'b0;
    bus.debug = 1'b0;
    step();
    check_val("prio_rst_mem_sel", bus.alive_out_selector, 16'h0000);
    check_val("prio_rst_mem_vga", bus.alive_out_vga, 16'h0000);

    // Read-during-write of 1234 over 3300 at addr 1.
    bus.debug = 1'b1;
    step();
    check_val("rdw_seed_sel", bus.alive_out_selector, 16'h3300);
    bus.debug             = 1'b0;
    bus.write_enb         = 1'b1;
    bus.alive_in_selector = 16'h1234;
    step();
`ifdef BLOCK_MEM_WRITE_FORWARD_EN
    check_val("rdw_sel", bus.alive_out_selector, 16'h1234);
`else
    check_val("rdw_sel", bus.alive_out_selector, 16'h3300);
`endif
    check_val("rdw_vga", bus.alive_out_vga, 16'h3300);
    bus.write_enb = 1'b0;
    step();
    check_val("rdw_next_sel", bus.alive_out_selector, 16'h1234);
    check_val("rdw_next_vga", bus.alive_out_vga, 16'h1234);

    // Debug held over two edges reloads the seed each time.
    bus.debug = 1'b1;
    set_addr(2'd2, 2'd3);
    step();
    check_val("hold1_sel", bus.alive_out_selector, 16'h33CC);
    check_val("hold1_vga", bus.alive_out_vga, 16'h6186);
    set_addr(2'd1, 2'd0);
    step();
    check_val("hold2_sel", bus.alive_out_selector, 16'h3300);
    check_val("hold2_vga", bus.alive_out_vga, 16'h0700);
    bus.debug = 1'b0;
    step();
    check_val("hold3_sel", bus.alive_out_selector, 16'h3300);
    check_val("hold3_vga", bus.alive_out_vga, 16'h0700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
